muldiv_hilo: RTL

//  Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_hilo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; divide always iterates WIDTH steps.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] r;
    if (neg) r = ~v + ONE_W;
    else     r = v;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    logic [2*WIDTH-1:0] r;
    if (neg) r = ~v + ONE_2W;
    else     r = v;
    return r;
  endfunction

  logic [1:0]         state_r;
  logic [1:0]         op_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mq_r;
  logic [CW-1:0]      cnt_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               launch_s;
  logic               is_signed_s;
  logic               div_zero_s;
  logic               launch_fin_s;
  logic               calc_fin_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   launch_hi_s;
  logic [WIDTH-1:0]   launch_lo_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   mq_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;
  logic [2*WIDTH-1:0] fast_prod_s;
`endif

  assign busy = (state_r == ST_CALC);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Launch decode: operand magnitudes and ops that finish without iterating
  always_comb begin
    launch_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    is_signed_s = ~op[0];
    div_zero_s  = op[1] && (src_b == ZERO_W);
    a_mag_s     = neg_if(src_a, is_signed_s && src_a[WIDTH-1]);
    b_mag_s     = neg_if(src_b, is_signed_s && src_b[WIDTH-1]);
`ifdef MULDIV_FAST_MUL_EN
    a_ext_s      = is_signed_s ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {ZERO_W, src_a};
    b_ext_s      = is_signed_s ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {ZERO_W, src_b};
    fast_prod_s  = a_ext_s * b_ext_s;
    launch_fin_s = launch_s && (div_zero_s || !op[1]);
    if (div_zero_s) begin
      launch_hi_s = src_a;
      launch_lo_s = ONES_W;
    end else begin
      launch_hi_s = fast_prod_s[2*WIDTH-1:WIDTH];
      launch_lo_s = fast_prod_s[WIDTH-1:0];
    end
`else
    launch_fin_s = launch_s && div_zero_s;
    launch_hi_s  = src_a;
    launch_lo_s  = ONES_W;
`endif
  end

  // One iteration: shift-add multiply on {acc,mq}, or restoring divide step
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (mq_r[0] ? {1'b0, mag_b_r} : {1'b0, ZERO_W});
    div_shift_s = {acc_r, mq_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mag_b_r};
    if (op_r[1]) begin
      if (!div_diff_s[WIDTH]) begin
        acc_nxt_s = div_diff_s[WIDTH-1:0];
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = div_shift_s[WIDTH-1:0];
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = mul_sum_s[WIDTH:1];
      mq_nxt_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step; remainder follows the dividend's sign
  always_comb begin
    calc_fin_s = (state_r == ST_CALC) && (cnt_r == CNT_LAST);
    prod_s     = neg_if_2w({acc_nxt_s, mq_nxt_s}, neg_res_r);
    if (op_r[1]) begin
      res_hi_s = neg_if(acc_nxt_s, neg_rem_r);
      res_lo_s = neg_if(mq_nxt_s, neg_res_r);
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer: operand capture, iteration and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      mag_b_r   <= ZERO_W;
      acc_r     <= ZERO_W;
      mq_r      <= ZERO_W;
      cnt_r     <= {CW{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (launch_s) begin
            op_r      <= op;
            neg_res_r <= is_signed_s && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_r <= is_signed_s && src_a[WIDTH-1];
            mag_b_r   <= b_mag_s;
            acc_r     <= ZERO_W;
            mq_r      <= a_mag_s;
            cnt_r     <= {CW{1'b0}};
            if (launch_fin_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_r <= acc_nxt_s;
          mq_r  <= mq_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (calc_fin_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_CALC;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // HI/LO: MTHI/MTLO win over a result write; both frozen while iterating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= ZERO_W;
      lo_r <= ZERO_W;
    end else begin
      if (hi_we && (state_r != ST_CALC)) hi_r <= src_a;
      else if (calc_fin_s)               hi_r <= res_hi_s;
      else if (launch_fin_s)             hi_r <= launch_hi_s;
      else                               hi_r <= hi_r;

      if (lo_we && (state_r != ST_CALC)) lo_r <= src_a;
      else if (calc_fin_s)               lo_r <= res_lo_s;
      else if (launch_fin_s)             lo_r <= launch_lo_s;
      else                               lo_r <= lo_r;
    end
  end

endmodule
